dist_ascii_framer: RTL

Converts one packed-BCD distance reading from the BCD converter into a human-readable ASCII line, e.g. `0123 cm` followed by CR LF. It sits between the `HC_SR04`/`BCD` path and `uart_tx`. It accepts one reading per frame over a valid/ready handshake and emits one byte per handshake on its byte side, which drives `uart_tx` `data`/`valid`/`ready` directly.

---
 rtl/dist_ascii_framer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dist_ascii_framer.sv
// Packed-BCD distance reading to ASCII line framer ("dddd cm\r\n") for uart_tx.
// Optional LEADING_ZERO_BLANK_EN: omit leading zero digits, keeping at least one.
module dist_ascii_framer #(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    bcd_valid,
   output logic                    bcd_ready,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready
);

   localparam int BCD_W    = 4 * NUM_DIGITS;
   localparam int LAST_IDX = NUM_DIGITS + 4;
   localparam int IDX_W    = $clog2(LAST_IDX + 1);

   localparam logic [0:0]       IDLE = 1'b0;
   localparam logic [0:0]       SEND = 1'b1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

   logic [0:0]            state_r;
   logic [IDX_W-1:0]      idx_r;
   logic [BCD_W-1:0]      shadow_r;
   logic [DATA_WIDTH-1:0] tx_data_r;
   logic                  tx_valid_r;
   logic                  bcd_ready_r;

   logic [0:0]            state_s;
   logic [IDX_W-1:0]      idx_s;
   logic [BCD_W-1:0]      shadow_s;
   logic [DATA_WIDTH-1:0] tx_data_s;
   logic                  tx_valid_s;
   logic                  bcd_ready_s;
   logic [IDX_W-1:0]      start_s;

   function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
      logic [7:0] a;
      if (nib <= 4'd9) begin
         a = 8'h30 + {4'h0, nib};
      end else begin
         a = 8'h3F;
      end
      return a;
   endfunction

   // Byte at a given line position: digits MSD first, then " cm\r\n".
   function automatic logic [7:0] frame_byte(input logic [BCD_W-1:0] rd,
                                             input logic [IDX_W-1:0] idx);
      logic [7:0]       b;
      logic [IDX_W-1:0] tail;
      b    = 8'h00;
      tail = idx - IDX_W'(NUM_DIGITS);
      if (idx < IDX_W'(NUM_DIGITS)) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
               b = ascii_digit(rd[4*(NUM_DIGITS-1-d) +: 4]);
            end else begin
               b = b;
            end
         end
      end else begin
         case (tail)
            IDX_W'(0): b = 8'h20;
            IDX_W'(1): b = 8'h63;
            IDX_W'(2): b = 8'h6D;
            IDX_W'(3): b = 8'h0D;
            default:   b = 8'h0A;
         endcase
      end
      return b;
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // First non-zero digit position, capped so at least the last digit is sent.
   function automatic logic [IDX_W-1:0] start_index(input logic [BCD_W-1:0] rd);
      logic [IDX_W-1:0] s;
      s = IDX_W'(NUM_DIGITS - 1);
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         if (rd[4*(NUM_DIGITS-1-d) +: 4] != 4'h0) begin
            s = IDX_W'(d);
         end else begin
            s = s;
         end
      end
      return s;
   endfunction

   // Start position derived from the reading being offered.
   always_comb begin
      start_s = start_index(bcd_in);
   end
`else
   // Fixed-width lines always begin at the first digit.
   always_comb begin
      start_s = {IDX_W{1'b0}};
   end
`endif

   // Next-state and next-output logic for capture, byte advance and frame end.
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      shadow_s    = shadow_r;
      tx_data_s   = tx_data_r;
      tx_valid_s  = tx_valid_r;
      bcd_ready_s = bcd_ready_r;
      case (state_r)
         IDLE: begin
            if (bcd_valid && bcd_ready_r) begin
               state_s     = SEND;
               shadow_s    = bcd_in;
               idx_s       = start_s;
               tx_data_s   = DATA_WIDTH'(frame_byte(bcd_in, start_s));
               tx_valid_s  = 1'b1;
               bcd_ready_s = 1'b0;
            end else begin
               state_s     = IDLE;
            end
         end
         SEND: begin
            if (tx_ready && tx_valid_r) begin
               if (idx_r == LAST) begin
                  state_s     = IDLE;
                  idx_s       = {IDX_W{1'b0}};
                  tx_data_s   = {DATA_WIDTH{1'b0}};
                  tx_valid_s  = 1'b0;
                  bcd_ready_s = 1'b1;
               end else begin
                  idx_s       = idx_r + IDX_W'(1);
                  tx_data_s   = DATA_WIDTH'(frame_byte(shadow_r, idx_r + IDX_W'(1)));
               end
            end else begin
               state_s = SEND;
            end
         end
         default: begin
            state_s     = IDLE;
            idx_s       = {IDX_W{1'b0}};
            shadow_s    = {BCD_W{1'b0}};
            tx_data_s   = {DATA_WIDTH{1'b0}};
            tx_valid_s  = 1'b0;
            bcd_ready_s = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= {IDX_W{1'b0}};
         shadow_r    <= {BCD_W{1'b0}};
         tx_data_r   <= {DATA_WIDTH{1'b0}};
         tx_valid_r  <= 1'b0;
         bcd_ready_r <= 1'b1;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         shadow_r    <= shadow_s;
         tx_data_r   <= tx_data_s;
         tx_valid_r  <= tx_valid_s;
         bcd_ready_r <= bcd_ready_s;
      end
   end

   assign tx_data   = tx_data_r;
   assign tx_valid  = tx_valid_r;
   assign bcd_ready = bcd_ready_r;

endmodule
